// File: rtl/serial_arith_pkg.sv
// ----------------------------------------------------------------------------
// serial_arith_pkg
// Shared types for the bit-serial arithmetic blocks.
//   state_t : control state of the serial subtractor (IDLE, RUN, DONE)
// Width-dependent constants (counter width) are computed inside each module
// because they depend on that module's WIDTH parameter.
// ----------------------------------------------------------------------------
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_arith_pkg

// File: rtl/full_subtractor.sv
// ----------------------------------------------------------------------------
// full_subtractor
// One-bit combinational full subtractor: a - b - bin.
// Ports:
//   a    in  1  minuend bit
//   b    in  1  subtrahend bit
//   bin  in  1  borrow in
//   d    out 1  difference bit
//   bout out 1  borrow out
// ----------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic axb_s;

    assign axb_s = a ^ b;
    assign d     = axb_s ^ bin;
    // Borrow when the minuend bit is 0 and the subtrahend bit is 1, or when
    // both bits are equal and a borrow is already pending.
    assign bout  = (~a & b) | (~axb_s & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit subtractor, diff = a - b - bin, processed LSB first,
// one bit per clock through a single full_subtractor cell.
// Parameters:
//   WIDTH     operand/result width in bits (>= 2)
// Ports:
//   clk       in  1      rising-edge clock
//   rst       in  1      synchronous active-high reset
//   in_valid  in  1      operands a, b, bin presented
//   in_ready  out 1      operands can be accepted this cycle
//   a         in  WIDTH  minuend
//   b         in  WIDTH  subtrahend
//   bin       in  1      borrow in
//   out_valid out 1      result held on diff/bout
//   out_ready in  1      consumer accepts result this cycle
//   diff      out WIDTH  (a - b - bin) mod 2^WIDTH
//   bout      out 1      1 iff a < b + bin (unsigned)
//   busy      out 1      high while bits are being processed
// Timing: operands accepted on edge T, out_valid is high after edge T+WIDTH.
// In DONE, in_ready follows out_ready so a result can be drained and new
// operands captured on the same edge.
// ----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    import serial_arith_pkg::*;

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] diff_r;
    logic [CNT_W-1:0] cnt_r;
    logic             borrow_r;
    logic             bout_r;
    logic             d_s;
    logic             borrow_next_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             last_s;

    // Single arithmetic cell fed from the LSBs of the operand shifters.
    full_subtractor u_fs (
        .a    (a_sr_r[0]),
        .b    (b_sr_r[0]),
        .bin  (borrow_r),
        .d    (d_s),
        .bout (borrow_next_s)
    );

    assign last_s   = (state_r == RUN) && (cnt_r == LAST_CNT);
    assign accept_s = in_valid & in_ready_s;

    // Next-state and input-side ready decode.
    always_comb begin
        in_ready_s   = 1'b0;
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                in_ready_s = 1'b0;
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                // Draining the result frees the datapath on the same edge.
                in_ready_s = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        state_next_s = RUN;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                in_ready_s   = 1'b0;
                state_next_s = IDLE;
            end
        endcase
    end

    // State register, operand shifters, bit counter, borrow and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            a_sr_r   <= {WIDTH{1'b0}};
            b_sr_r   <= {WIDTH{1'b0}};
            diff_r   <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            borrow_r <= 1'b0;
            bout_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                a_sr_r   <= a;
                b_sr_r   <= b;
                borrow_r <= bin;
                cnt_r    <= {CNT_W{1'b0}};
            end else if (state_r == RUN) begin
                a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
                b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
                // Result bits enter at the MSB so after WIDTH shifts the
                // first (LSB) difference bit sits at position 0.
                diff_r   <= {d_s, diff_r[WIDTH-1:1]};
                borrow_r <= borrow_next_s;
                cnt_r    <= cnt_r + CNT_ONE;
                if (last_s) begin
                    bout_r <= borrow_next_s;
                end
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r == RUN);
    assign diff      = diff_r;
    assign bout      = bout_r;

endmodule : serial_subtractor
